// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter: round-robin between ALU (A) and load unit (B) into one
// register-file write port, plus a pending-write scoreboard for hazard queries.
module riscv_wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    input  logic            sb_set,
    input  logic [4:0]      sb_set_rd,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rf_wen,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_data
);

    logic            rr_ptr_p0;
    logic            grant_a;
    logic            grant_b;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            rf_wen_p1;
    logic [4:0]      rf_rd_p1;
    logic [XLEN-1:0] rf_data_p1;
    logic [31:0]     busy_p1;
    logic [31:0]     busy_nxt;

    // rr_ptr_p0 = 0 favours A, 1 favours B when both request
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            grant_a = a_valid && (!b_valid || !rr_ptr_p0);
            grant_b = b_valid && (!a_valid ||  rr_ptr_p0);
        end
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign sel_rd   = grant_b ? b_rd   : a_rd;
    assign sel_data = grant_b ? b_data : a_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_p0 <= 1'b0;
        end else if (a_valid && b_valid) begin
            rr_ptr_p0 <= grant_a;
        end
    end

    // ---- stage p1: registered write port ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen_p1  <= 1'b0;
            rf_rd_p1   <= '0;
            rf_data_p1 <= '0;
        end else if ((grant_a || grant_b) && sel_rd != 5'd0) begin
            rf_wen_p1  <= 1'b1;
            rf_rd_p1   <= sel_rd;
            rf_data_p1 <= sel_data;
        end else begin
            rf_wen_p1  <= 1'b0;
        end
    end

    assign rf_wen  = rf_wen_p1;
    assign rf_rd   = rf_rd_p1;
    assign rf_data = rf_data_p1;

    // A same-cycle reservation is newer than the retiring write, so set wins
    always_comb begin
        busy_nxt = busy_p1;
        if (rf_wen_p1) begin
            busy_nxt[rf_rd_p1] = 1'b0;
        end
        if (sb_set && sb_set_rd != 5'd0) begin
            busy_nxt[sb_set_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_p1 <= '0;
        end else begin
            busy_p1 <= busy_nxt;
        end
    end

    assign rs1_busy = busy_p1[rs1_addr] ||
                      (rf_wen_p1 && rf_rd_p1 == rs1_addr && rf_rd_p1 != 5'd0);
    assign rs2_busy = busy_p1[rs2_addr] ||
                      (rf_wen_p1 && rf_rd_p1 == rs2_addr && rf_rd_p1 != 5'd0);

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Bench for riscv_wb_arbiter: per-cycle reference model with an expected-write
// queue, directed scenarios followed by constrained-random traffic.
module tb_riscv_wb_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            a_valid, b_valid, a_ready, b_ready;
    logic [4:0]      a_rd, b_rd;
    logic [XLEN-1:0] a_data, b_data;
    logic            sb_set;
    logic [4:0]      sb_set_rd, rs1_addr, rs2_addr;
    logic            rs1_busy, rs2_busy;
    logic            rf_wen;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_data;

    always #5 clk = ~clk;

    riscv_wb_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .sb_set(sb_set), .sb_set_rd(sb_set_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_data(rf_data)
    );

    typedef struct {
        logic            rst;
        logic            wen;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        m_ptr;
    logic [31:0] m_busy;
    logic        m_wen;
    logic [4:0]  m_rd;
    logic        ga, gb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic busy_model(input logic [4:0] addr);
        return m_busy[addr] || (m_wen && m_rd == addr && addr != 5'd0);
    endfunction

    // One clock cycle: inputs are set by the caller just after a falling edge.
    task automatic step();
        exp_t e;
        #1;
        if (rst) begin
            ga = 1'b0;
            gb = 1'b0;
        end else begin
            ga = a_valid && (!b_valid || !m_ptr);
            gb = b_valid && (!a_valid ||  m_ptr);
        end
        check("a_ready", a_ready, ga);
        check("b_ready", b_ready, gb);
        if (!rst) begin
            check("rs1_busy", rs1_busy, busy_model(rs1_addr));
            check("rs2_busy", rs2_busy, busy_model(rs2_addr));
        end
        e.rst  = rst;
        e.wen  = (ga && a_rd != 5'd0) || (gb && b_rd != 5'd0);
        e.rd   = rst ? 5'd0 : (gb ? b_rd : a_rd);
        e.data = rst ? '0 : (gb ? b_data : a_data);
        exp_q.push_back(e);
        if (rst) begin
            m_ptr  = 1'b0;
            m_busy = '0;
        end else begin
            if (a_valid && b_valid) m_ptr = ga;
            if (m_wen) m_busy[m_rd] = 1'b0;
            if (sb_set && sb_set_rd != 5'd0) m_busy[sb_set_rd] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check("rf_wen", rf_wen, e.wen);
        if (e.wen || e.rst) begin
            check("rf_rd", rf_rd, e.rd);
            check("rf_data", rf_data, e.data);
        end
        m_wen = e.wen;
        m_rd  = e.rd;
    endtask

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; sb_set = 0;
    endtask

    initial begin
        m_ptr = 0; m_busy = '0; m_wen = 0; m_rd = 0;
        rst = 1; a_valid = 1; b_valid = 1;
        a_rd = 5'd3; a_data = 32'h1111_0003; b_rd = 5'd4; b_data = 32'h2222_0004;
        sb_set = 1; sb_set_rd = 5'd6; rs1_addr = 5'd6; rs2_addr = 5'd0;
        @(negedge clk);
        // reset with both requesters active
        step(); step();
        rst = 0;
        // contention: A,B,A,B back to back; first grant goes to A
        sb_set = 0;
        a_rd = 5'd1; a_data = 32'hA000_0001; b_rd = 5'd2; b_data = 32'hB000_0002;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ga) begin a_rd = a_rd + 5'd2; a_data = a_data + 32'd2; end
            if (gb) begin b_rd = b_rd + 5'd2; b_data = b_data + 32'd2; end
        end
        idle_inputs();
        // lone A write
        a_valid = 1; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        step();
        // B write to x0 is accepted but suppressed
        b_valid = 1; b_rd = 5'd0; b_data = 32'h0BAD_F00D;
        step();
        idle_inputs();
        step();
        // scoreboard set / clear of x7
        sb_set = 1; sb_set_rd = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd5;
        step();
        sb_set = 0;
        step();
        a_valid = 1; a_rd = 5'd7; a_data = 32'h0000_0777;
        step();
        a_valid = 0;
        step(); step(); step();
        // set and clear of x9 in the same cycle
        sb_set = 1; sb_set_rd = 5'd9; rs2_addr = 5'd9;
        step();
        sb_set = 0; a_valid = 1; a_rd = 5'd9; a_data = 32'h0000_0999;
        step();
        a_valid = 0; sb_set = 1; sb_set_rd = 5'd9;
        step();
        sb_set = 0;
        step(); step();
        // reset mid-transfer, then contention after release goes to A
        a_valid = 1; b_valid = 1; a_rd = 5'd10; a_data = 32'hA10; b_rd = 5'd11; b_data = 32'hB11;
        step();
        if (ga) begin a_rd = 5'd12; a_data = 32'hA12; end
        if (gb) begin b_rd = 5'd13; b_data = 32'hB13; end
        rst = 1;
        step();
        rst = 0;
        step(); step();
        // randomised traffic with hold-until-accepted requesters
        idle_inputs();
        ga = 0; gb = 0;
        for (int i = 0; i < 400; i++) begin
            if (!a_valid || ga) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_rd    = 5'($urandom_range(0, 31));
                a_data  = $urandom;
            end
            if (!b_valid || gb) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_rd    = 5'($urandom_range(0, 31));
                b_data  = $urandom;
            end
            sb_set    = ($urandom_range(0, 2) == 0);
            sb_set_rd = 5'($urandom_range(0, 31));
            rs1_addr  = $urandom_range(0, 1) ? m_rd : 5'($urandom_range(0, 31));
            rs2_addr  = 5'($urandom_range(0, 31));
            rst       = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/riscv_wb_arbiter.md
RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

Interface
REQ-001 Parameter: XLEN, 32, data width of the register-file write port.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 a_valid  input  1  requester A (ALU writeback) holds a write.
REQ-005 a_rd  input  5  requester A destination register.
REQ-006 a_data  input  XLEN  requester A write data.
REQ-007 a_ready  output  1  requester A write accepted this cycle.
REQ-008 b_valid / b_rd / b_data / b_ready  same widths  requester B (load unit writeback).
REQ-009 sb_set  input  1  issue stage reserves a destination register.
REQ-010 sb_set_rd  input  5  register being reserved.
REQ-011 rs1_addr, rs2_addr  input  5 each  hazard query addresses.
REQ-012 rs1_busy, rs2_busy  output  1 each  queried register has a pending write (combinational).
REQ-013 rf_wen  output  1  register-file write enable (registered).
REQ-014 rf_rd  output  5  register-file write address (registered).
REQ-015 rf_data  output  XLEN  register-file write data (registered).

Function
REQ-016 Handshake: a transfer occurs on a cycle where X_valid and X_ready are both 1; X_ready is a combinational function of both valids and the arbitration state.
REQ-017 Requesters keep valid, rd and data stable until accepted; the block does not need to tolerate withdrawal.
REQ-018 At most one of a_ready, b_ready is 1 in any cycle.
REQ-019 Single valid: that requester is granted immediately.
REQ-020 Both valid: grant the requester indicated by a 1-bit round-robin pointer; pointer initialises to A after reset.
REQ-021 Pointer flips to the non-granted requester only on a cycle when both valids are 1 and a grant occurs; a lone grant leaves the pointer unchanged.
REQ-022 Granted transfer drives rf_wen=1, rf_rd, rf_data on the next cycle (latency 1); otherwise rf_wen=0 and rf_rd/rf_data hold their last values.
REQ-023 A grant with rd=0 is accepted (ready=1) but produces rf_wen=0 next cycle; x0 is never written.
REQ-024 Scoreboard: 32-bit busy vector; bit 0 permanently 0.
REQ-025 sb_set=1 with sb_set_rd!=0 sets the busy bit next cycle.
REQ-026 Bit for rf_rd clears on the cycle rf_wen=1 is presented, i.e. it reads 0 from the following cycle.
REQ-027 Set and clear of the same register in one cycle: set wins (newer reservation).
REQ-028 rsN_busy = busy[rsN_addr] OR (rf_wen AND rf_rd==rsN_addr AND rf_rd!=0), so a register whose write is visible on the write port this cycle still reports busy.
REQ-029 Back-to-back grants are allowed every cycle; no bubble between consecutive transfers.
REQ-030 No FIFO; throughput is one write per cycle total.

Reset
REQ-031 While rst=1: a_ready=0, b_ready=0, rf_wen=0, rf_rd=0, rf_data=0, busy vector all 0, pointer=A.
REQ-032 rst asserted mid-transfer discards any pending grant; no write is emitted on the cycle after rst deasserts unless a new grant occurs on the deassertion cycle.
REQ-033 rsN_busy outputs read 0 on the first cycle after reset.

Verification
REQ-034 A only, a_rd=5, a_data=0xDEADBEEF -> a_ready=1 same cycle; next cycle rf_wen=1, rf_rd=5, rf_data=0xDEADBEEF.
REQ-035 A and B valid for 4 cycles after reset -> grants A,B,A,B; rf_wen=1 on 4 consecutive cycles.
REQ-036 b_valid, b_rd=0 -> b_ready=1; next cycle rf_wen=0.
REQ-037 sb_set rd=7; query rs1_addr=7 -> rs1_busy=1 until the cycle after rf_wen=1 with rf_rd=7, then 0.
REQ-038 sb_set rd=9 in the same cycle as rf_wen=1 rf_rd=9 -> busy[9] remains 1.
REQ-039 rst=1 with both valids high -> both ready=0, rf_wen=0, all busy 0; first grant after release goes to A.
